// File: rtl/bus_slave_responder.sv
// Byte-addressed storage slave with independent write and read channels, each paced by a wait-state FSM.
// Optional: define BUS_SLAVE_DECERR_EN to answer out-of-range accesses with SLVERR (2'b10).
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no transaction; valid=1 latches the request
// S_WAIT | request latched, down-counter running for WAIT_CYCLES cycles
// S_RESP | one-cycle completion strobe, storage written/sampled on entry

module bus_slave_responder #(
  parameter logic [7:0] BASE_ADDR   = 8'h00,
  parameter int         DEPTH       = 64,
  parameter int         WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       w_valid,
  input  logic [7:0] w_addr,
  input  logic [7:0] w_data,
  output logic       w_ready,
  output logic [1:0] w_resp,
  input  logic       r_valid,
  input  logic [7:0] r_addr,
  output logic       r_ready,
  output logic [7:0] r_data,
  output logic [1:0] r_resp
);

  localparam int         IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [8:0] LO        = {1'b0, BASE_ADDR};
  localparam logic [8:0] DEPTH9    = 9'(DEPTH);
  localparam logic [1:0] RESP_OK   = 2'b00;
`ifdef BUS_SLAVE_DECERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [7:0] mem [0:DEPTH-1];

  state_t     w_state, w_next;
  logic [3:0] w_cnt;
  logic [7:0] w_addr_q, w_data_q;
  logic       w_accept;
  logic [7:0] w_addr_eff, w_data_eff;
  logic [8:0] w_diff;
  logic       w_inr;
  logic [IW-1:0] w_idx;
  logic       w_ready_d, w_we;
  logic [1:0] w_resp_d;

  state_t     r_state, r_next;
  logic [3:0] r_cnt;
  logic [7:0] r_addr_q;
  logic       r_accept;
  logic [7:0] r_addr_eff;
  logic [8:0] r_diff;
  logic       r_inr;
  logic [IW-1:0] r_idx;
  logic       r_ready_d;
  logic [1:0] r_resp_d;
  logic [7:0] r_data_d;

  // With WAIT_CYCLES=0 RESP is entered on the accepting edge, so the live inputs are used there.
  assign w_accept   = (w_state == S_IDLE) && w_valid;
  assign w_addr_eff = (w_state == S_IDLE) ? w_addr : w_addr_q;
  assign w_data_eff = (w_state == S_IDLE) ? w_data : w_data_q;
  // Offset wraps to >=257 when addr < BASE_ADDR, so one unsigned compare covers both bounds.
  assign w_diff     = {1'b0, w_addr_eff} - LO;
  assign w_inr      = (w_diff < DEPTH9);
  assign w_idx      = w_diff[IW-1:0];

  assign r_accept   = (r_state == S_IDLE) && r_valid;
  assign r_addr_eff = (r_state == S_IDLE) ? r_addr : r_addr_q;
  assign r_diff     = {1'b0, r_addr_eff} - LO;
  assign r_inr      = (r_diff < DEPTH9);
  assign r_idx      = r_diff[IW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state  <= S_IDLE;
      w_cnt    <= 4'd0;
      w_addr_q <= 8'h00;
      w_data_q <= 8'h00;
      w_ready  <= 1'b0;
      w_resp   <= 2'b00;
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_addr_q <= 8'h00;
      r_ready  <= 1'b0;
      r_resp   <= 2'b00;
      r_data   <= 8'h00;
    end else begin
      w_state <= w_next;
      if (w_accept) begin
        w_cnt    <= WAIT_LOAD;
        w_addr_q <= w_addr;
        w_data_q <= w_data;
      end else if ((w_state == S_WAIT) && (w_cnt != 4'd0)) begin
        w_cnt <= w_cnt - 4'd1;
      end
      w_ready <= w_ready_d;
      w_resp  <= w_resp_d;

      r_state <= r_next;
      if (r_accept) begin
        r_cnt    <= WAIT_LOAD;
        r_addr_q <= r_addr;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      r_ready <= r_ready_d;
      r_resp  <= r_resp_d;
      r_data  <= r_data_d;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      S_IDLE: if (w_valid) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (w_cnt == 4'd0) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      S_IDLE: if (r_valid) r_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == 4'd0) r_next = S_RESP;
      S_RESP: r_next = S_IDLE;
      default: r_next = S_IDLE;
    endcase
  end

  // Outputs are computed for the cycle after the edge, then registered.
  always_comb begin
    w_ready_d = (w_next == S_RESP);
    w_resp_d  = 2'b00;
    w_we      = 1'b0;
    if (w_ready_d) begin
      w_resp_d = w_inr ? RESP_OK : RESP_OOR;
      w_we     = w_inr;
    end
  end

  always_comb begin
    r_ready_d = (r_next == S_RESP);
    r_resp_d  = 2'b00;
    r_data_d  = 8'h00;
    if (r_ready_d) begin
      r_resp_d = r_inr ? RESP_OK : RESP_OOR;
      if (r_inr) r_data_d = mem[r_idx];
    end
  end

  // Non-blocking update means a same-edge read samples the pre-write word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (w_we) begin
      mem[w_idx] <= w_data_eff;
    end
  end

endmodule

// File: doc/bus_slave_responder.md
BUS_SLAVE_RESPONDER -- requirements
Module: bus_slave_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h00: first byte address decoded by this slave.
REQ-002 SHALL have parameter DEPTH, default 64: number of 8-bit storage words, range 1..256.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1: wait states inserted before each response, range 0..15.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port w_valid  input  1  write request present.
REQ-007 SHALL have port w_addr  input  8  write byte address.
REQ-008 SHALL have port w_data  input  8  write data.
REQ-009 SHALL have port w_ready  output  1  write completion strobe.
REQ-010 SHALL have port w_resp  output  2  write response, valid while w_ready=1.
REQ-011 SHALL have port r_valid  input  1  read request present.
REQ-012 SHALL have port r_addr  input  8  read byte address.
REQ-013 SHALL have port r_ready  output  1  read completion strobe.
REQ-014 SHALL have port r_data  output  8  read data, valid while r_ready=1.
REQ-015 SHALL have port r_resp  output  2  read response, valid while r_ready=1.

Function
REQ-016 SHALL run write and read channels as independent FSMs, states IDLE -> WAIT -> RESP -> IDLE.
REQ-017 SHALL, in IDLE with valid=1, latch addr (and w_data) at the clock edge and enter WAIT, or enter RESP directly when WAIT_CYCLES=0.
REQ-018 SHALL stay in WAIT for exactly WAIT_CYCLES cycles, counted by a per-channel down-counter, then enter RESP.
REQ-019 SHALL drive ready=1 for exactly one cycle in RESP, all outputs registered; ready latency = WAIT_CYCLES+1 cycles after the accepting edge.
REQ-020 SHALL ignore addr/data/valid changes during WAIT and RESP; only latched values are used.
REQ-021 SHALL return to IDLE after RESP; valid still high in that IDLE cycle starts a new transaction (back-to-back allowed, one idle cycle between strobes).
REQ-022 SHALL treat an address as in range when BASE_ADDR <= addr < BASE_ADDR+DEPTH, computed 9-bit wide so BASE_ADDR+DEPTH>255 cannot wrap; local index = addr-BASE_ADDR.
REQ-023 SHALL write the latched data to storage at the edge entering RESP, in-range only, with w_resp=2'b00.
REQ-024 SHALL sample storage for reads at the edge entering RESP, r_resp=2'b00.
REQ-025 SHALL, when a write and a read to the same index both enter RESP on the same edge, return pre-write data on r_data.
REQ-026 SHALL hold ready=0, resp=2'b00 and r_data=8'h00 in every cycle outside RESP.

Reset
REQ-027 SHALL, on rst_n=0 at any time, immediately force both FSMs to IDLE, counters to 0, ready to 0, resp to 2'b00, r_data to 8'h00, all storage words to 8'h00.
REQ-028 SHALL abandon an in-flight transaction on reset without storage update and without ready strobe; first accept possible on first rising edge with rst_n=1.

Configuration
REQ-029 SHALL, with macro BUS_SLAVE_DECERR_EN defined, answer out-of-range accesses with resp=2'b10 (SLVERR), r_data=8'h00, no storage change, same latency.
REQ-030 SHALL, without BUS_SLAVE_DECERR_EN, answer out-of-range accesses with resp=2'b00, r_data=8'h00, write silently dropped, same latency.

Verification
REQ-031 SHALL cover: reset, WAIT_CYCLES=1, write 0x12->0x05 then read 0x05 -> w_ready after 2 cycles with resp 00; r_ready after 2 cycles with r_data 0x12, resp 00.
REQ-032 SHALL cover: write 0x34->0x07 and read 0x07 asserted same cycle, old value 0x00 -> r_data 0x00; subsequent read returns 0x34.
REQ-033 SHALL cover: BASE_ADDR=8'h40, DEPTH=64, read 0x3F -> resp 10 with macro, 00 without; r_data 0x00 both; read 0x80 same result.
REQ-034 SHALL cover: WAIT_CYCLES=0, w_valid held high across 3 writes to 0x00..0x02 -> three one-cycle w_ready pulses, one idle cycle apart, all words updated.
REQ-035 SHALL cover: rst_n pulsed low during WAIT of write 0xAA->0x03 -> no w_ready, word 0x03 reads back 0x00 after reset.
REQ-036 SHALL cover: w_addr/w_data changed to 0x09/0xFF during WAIT of write 0x55->0x08 -> word 0x08=0x55, word 0x09 unchanged.
